// File: rtl/sum_tx_sequencer.sv
// Sums two 3-bit operands captured from push buttons.
// Sends "A+B=SS" as ASCII bytes to a UART transmitter.
// Optional feature: define TX_CRLF_EN to append CR/LF, giving an 8-byte frame.
module sum_tx_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       save_a_n,
    input  logic       save_b_n,
    input  logic [2:0] data_input,
    input  logic       tx_en,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       frame_busy,
    output logic [3:0] sum_out
);

`ifdef TX_CRLF_EN
    localparam int unsigned FrameLen = 8;
`else
    localparam int unsigned FrameLen = 6;
`endif
    localparam logic [2:0] LastIdx = 3'(FrameLen - 1);

    typedef enum logic [2:0] {StIdle, StCalc, StSend, StHold, StWaitDone} state_e;

    state_e      state_q, state_d;
    // Bits [1:0] form the synchronizer; bit [2] holds the previous synchronized level.
    logic [2:0]  sync_a_q, sync_a_d, sync_b_q, sync_b_d;
    logic [2:0]  reg_a_q, reg_a_d, reg_b_q, reg_b_d;
    logic        a_valid_q, a_valid_d, b_valid_q, b_valid_d;
    logic [2:0]  snap_a_q, snap_a_d, snap_b_q, snap_b_d;
    logic [3:0]  sum_q, sum_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_start_q, tx_start_d;
    logic        fall_a, fall_b;
    logic [3:0]  ones;
    logic [7:0]  frame_byte;

    assign fall_a     = sync_a_q[2] & ~sync_a_q[1];
    assign fall_b     = sync_b_q[2] & ~sync_b_q[1];
    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign sum_out    = sum_q;
    assign frame_busy = (state_q != StIdle);

    // Select the frame byte for the current index from the snapshot and registered sum.
    always_comb begin
        ones       = (sum_q >= 4'd10) ? (sum_q - 4'd10) : sum_q;
        frame_byte = 8'h00;
        case (idx_q)
            3'd0:    frame_byte = {5'b00110, snap_a_q};
            3'd1:    frame_byte = 8'h2B;
            3'd2:    frame_byte = {5'b00110, snap_b_q};
            3'd3:    frame_byte = 8'h3D;
            3'd4:    frame_byte = (sum_q >= 4'd10) ? 8'h31 : 8'h30;
            3'd5:    frame_byte = {4'h3, ones};
`ifdef TX_CRLF_EN
            3'd6:    frame_byte = 8'h0D;
            3'd7:    frame_byte = 8'h0A;
`endif
            default: frame_byte = 8'h00;
        endcase
    end

    // Next-state: synchronizers, operand capture, and frame sequencing FSM.
    always_comb begin
        sync_a_d   = {sync_a_q[1:0], save_a_n};
        sync_b_d   = {sync_b_q[1:0], save_b_n};
        state_d    = state_q;
        reg_a_d    = reg_a_q;
        reg_b_d    = reg_b_q;
        a_valid_d  = a_valid_q;
        b_valid_d  = b_valid_q;
        snap_a_d   = snap_a_q;
        snap_b_d   = snap_b_q;
        sum_d      = sum_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (a_valid_q && b_valid_q && tx_en) begin
                    state_d = StCalc;
                end
            end
            StCalc: begin
                sum_d     = {1'b0, reg_a_q} + {1'b0, reg_b_q};
                snap_a_d  = reg_a_q;
                snap_b_d  = reg_b_q;
                a_valid_d = 1'b0;
                b_valid_d = 1'b0;
                idx_d     = 3'd0;
                state_d   = StSend;
            end
            StSend: begin
                if (!tx_busy) begin
                    tx_data_d  = frame_byte;
                    tx_start_d = 1'b1;
                    state_d    = StHold;
                end
            end
            // Gives the transmitter one cycle to raise busy before it is sampled.
            StHold: begin
                state_d = StWaitDone;
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    if (idx_q == LastIdx) begin
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StSend;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A fresh edge overrides the CALC clear so the new operand is kept.
        if (fall_a) begin
            reg_a_d   = data_input;
            a_valid_d = 1'b1;
        end
        if (fall_b) begin
            reg_b_d   = data_input;
            b_valid_d = 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            sync_a_q   <= 3'b111;
            sync_b_q   <= 3'b111;
            reg_a_q    <= 3'd0;
            reg_b_q    <= 3'd0;
            a_valid_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            snap_a_q   <= 3'd0;
            snap_b_q   <= 3'd0;
            sum_q      <= 4'd0;
            idx_q      <= 3'd0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_a_q   <= sync_a_d;
            sync_b_q   <= sync_b_d;
            reg_a_q    <= reg_a_d;
            reg_b_q    <= reg_b_d;
            a_valid_q  <= a_valid_d;
            b_valid_q  <= b_valid_d;
            snap_a_q   <= snap_a_d;
            snap_b_q   <= snap_b_d;
            sum_q      <= sum_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

endmodule
